// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter
//   Round-robin arbiter that shares one valid/ready output channel among
//   NUM_REQ requesters. Each requester uses a 4-phase req/ack handshake.
//   The winner's data is captured and presented downstream. The requester
//   is acknowledged after the word is accepted. A stall watchdog pulses
//   timeout_err when the downstream holds off for TIMEOUT cycles.
//
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   req          : per-requester request level
//   req_data     : requester i data at [i*DATA_W +: DATA_W], stable while req[i]
//   ack          : per-requester acknowledge level (at most one bit high)
//   out_valid    : downstream valid, held until out_ready
//   out_ready    : downstream ready
//   out_data     : captured data of the granted requester
//   out_src      : index of the granted requester
//   busy         : high whenever a transfer is in flight (SEND or ACK)
//   timeout_err  : one-cycle pulse on stall timeout
module req_ack_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0]  out_src,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state_q;
  logic [SRC_W-1:0]    ptr_q;
  logic [SRC_W-1:0]    src_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                busy_q;
  logic                tmo_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                sel_found;
  logic [SRC_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_data;
  logic [SRC_W-1:0]    cand;

  // Round-robin pick: first set request searching upward from ptr_q+1 with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_data  = req_data[32'(cand)*DATA_W +: DATA_W];
      end
    end
  end

  // Transfer FSM with registered outputs and stall watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SRC_W'(NUM_REQ - 1);
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_found) begin
            data_q  <= sel_data;
            src_q   <= sel_idx;
            ptr_q   <= sel_idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            ack_q   <= NUM_REQ'(1) << src_q;
            state_q <= ACK;
          end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            // Counter saturates, so the pulse fires once per stalled transfer.
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              tmo_q <= 1'b1;
            end
          end
        end
        ACK: begin
          if (!req[src_q]) begin
            ack_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_src     = src_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule
